// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper: walks the data memory through its debug port and streams
// every word to a UART transmitter, MSB byte first, one byte per tx handshake.
// The memory's debug counter is advanced with o_debug after each word, and a
// settle cycle lets its falling-edge update reach i_mem_debug before the next
// capture.
module debug_mem_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_mem_debug,
    output logic                  o_debug,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int WCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_ADVANCE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WCW-1:0]          word_cnt;
    logic [1:0]              byte_cnt;
    logic [DATA_WIDTH-1:0]   shreg;

    // The byte on the wire is always the top byte of the shift register; it
    // only changes on the edge that enters SEND, so it holds between sends.
    assign o_tx_data = shreg[DATA_WIDTH-1 -: 8];

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_d    = state_q;
        o_tx_start = 1'b0;
        o_debug    = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) state_d = (byte_cnt == 2'd3) ? S_ADVANCE : S_SEND;
            end
            S_ADVANCE: begin
                o_debug = 1'b1;
                state_d = (word_cnt == LAST_WORD) ? S_DONE : S_SETTLE;
            end
            S_SETTLE: state_d = S_LOAD;
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word/byte counters and the capture/shift register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_LOAD: shreg <= i_mem_debug;
                S_WAIT: begin
                    if (i_tx_done && byte_cnt != 2'd3) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {shreg[DATA_WIDTH-9:0], 8'h00};
                    end
                end
                S_ADVANCE: begin
                    // Wraps to 0 after the last word, matching the memory counter.
                    word_cnt <= word_cnt + 1'b1;
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Directed bench for debug_mem_dumper with a falling-edge memory model and a
// transmitter model that answers each o_tx_start after tx_lat cycles.
module tb_debug_mem_dumper;

    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          start_drv;
    logic          spur_en;
    logic          i_start;
    logic          i_tx_done;
    logic [DW-1:0] i_mem_debug;
    logic          o_debug;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          o_busy;
    logic          o_done;

    logic [DW-1:0] mem [DEPTH];
    logic [4:0]    mem_cnt;
    int            tx_lat;
    int            tx_cnt;
    logic          tx_done_m;

    int            cyc = 0;
    logic [7:0]    q[$];
    int            n_dbg, n_done, first_cyc, start_cyc;
    logic [4:0]    first_mem;
    int            n_chk = 0;
    int            n_fail = 0;
    bit            ok;

    always #5 clk = ~clk;

    debug_mem_dumper #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_mem_debug(i_mem_debug),
        .o_debug    (o_debug),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Spurious start/done pulses land only in SEND and ADVANCE cycles.
    assign i_start     = start_drv | (spur_en & (o_tx_start | o_debug));
    assign i_tx_done   = tx_done_m | (spur_en & (o_tx_start | o_debug));
    assign i_mem_debug = mem[mem_cnt];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory debug counter: advances on the falling edge, cleared by system reset.
    always @(negedge clk or negedge i_reset) begin
        if (!i_reset)     mem_cnt <= '0;
        else if (o_debug) mem_cnt <= mem_cnt + 5'd1;
    end

    // Transmitter: one-cycle done pulse tx_lat cycles after a start strobe.
    always @(negedge clk) begin
        tx_done_m <= 1'b0;
        if (!i_reset) begin
            tx_cnt <= 0;
        end else if (o_tx_start) begin
            tx_cnt <= tx_lat;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_done_m <= 1'b1;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (i_reset) begin
            if (o_tx_start) begin
                if (q.size() == 0) begin
                    first_cyc = cyc;
                    first_mem = mem_cnt;
                end
                q.push_back(o_tx_data);
            end
            if (o_debug) n_dbg++;
            if (o_done)  n_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [DW-1:0] w;
        w = mem[i / 4];
        return w[8 * (3 - i % 4) +: 8];
    endfunction

    function automatic logic [7:0] qb(input int i);
        if (i < q.size()) return q[i];
        return 8'hEE;
    endfunction

    task automatic clr_mon;
        q.delete();
        n_dbg     = 0;
        n_done    = 0;
        first_cyc = -1;
        first_mem = 5'h1f;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1;
        start_drv = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_drv = 1'b0;
    endtask

    // Returns at mid-cycle of the DONE cycle, after the monitor has seen it.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #2;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic check_stream(input string tag);
        int nerr;
        nerr = 0;
        for (int i = 0; i < 4 * DEPTH; i++)
            if (qb(i) !== exp_byte(i)) nerr++;
        chk({tag, "_len"}, 32'(q.size()), 32'(4 * DEPTH));
        chk({tag, "_bytes_bad"}, 32'(nerr), 32'd0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, o_busy},     32'd0);
        chk({tag, "_start"}, {31'd0, o_tx_start}, 32'd0);
        chk({tag, "_debug"}, {31'd0, o_debug},    32'd0);
        chk({tag, "_done"},  {31'd0, o_done},     32'd0);
        chk({tag, "_data"},  {24'd0, o_tx_data},  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start_drv = 1'b0;
        spur_en   = 1'b0;
        tx_lat    = 3;
        i_reset   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[2]  = 32'd99;
        mem[31] = 32'd100;
        clr_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk_outs_zero("rst");
        @(posedge clk); #1;
        i_reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic dump
        clr_mon();
        pulse_start();
        wait_done(ok);
        chk("d1_done_seen", {31'd0, ok}, 32'd1);
        chk("d1_byte0", {24'd0, qb(0)}, 32'h00);
        chk("d1_latency", 32'(first_cyc - start_cyc), 32'd2);
        chk("d1_bytes8_11", {qb(8), qb(9), qb(10), qb(11)}, 32'h0000_0063);
        chk("d1_bytes124_127", {qb(124), qb(125), qb(126), qb(127)}, 32'h0000_0064);
        check_stream("d1");
        chk("d1_debug_pulses", 32'(n_dbg), 32'd32);
        chk("d1_done_pulses", 32'(n_done), 32'd1);
        @(posedge clk); #1;
        chk("d1_busy_after", {31'd0, o_busy}, 32'd0);

        // Spurious start / tx_done outside WAIT; start during DONE ignored
        clr_mon();
        spur_en = 1'b1;
        pulse_start();
        wait_done(ok);
        spur_en = 1'b0;
        chk("d2_done_seen", {31'd0, ok}, 32'd1);
        chk("d2_mem_at_start", {27'd0, first_mem}, 32'd0);
        check_stream("d2");
        chk("d2_debug_pulses", 32'(n_dbg), 32'd32);
        chk("d2_done_pulses", 32'(n_done), 32'd1);
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        chk("start_in_done_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("start_in_done_idle", {31'd0, o_busy}, 32'd0);

        // Back-to-back dumps, second started in the cycle after o_done
        clr_mon();
        pulse_start();
        wait_done(ok);
        chk("d3_done_seen", {31'd0, ok}, 32'd1);
        chk("d3_mem_at_start", {27'd0, first_mem}, 32'd0);
        check_stream("d3");
        clr_mon();
        pulse_start();
        wait_done(ok);
        chk("d4_done_seen", {31'd0, ok}, 32'd1);
        chk("d4_latency", 32'(first_cyc - start_cyc), 32'd2);
        chk("d4_mem_at_start", {27'd0, first_mem}, 32'd0);
        check_stream("d4");

        // Reset during WAIT of word 5 (byte 20 already strobed)
        @(posedge clk); #1;
        clr_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (q.size() >= 21) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rw_reached_word5", {31'd0, ok}, 32'd1);
        i_reset = 1'b0;
        #1;
        chk_outs_zero("rw");
        repeat (3) @(posedge clk);
        #2;
        chk("rw_no_done", 32'(n_done), 32'd0);
        chk("rw_no_more_bytes", 32'(q.size()), 32'd21);
        @(posedge clk); #1;
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        clr_mon();
        pulse_start();
        wait_done(ok);
        chk("rw_redump_done", {31'd0, ok}, 32'd1);
        check_stream("rw_redump");

        // Slow transmitter: first byte's done held off ~1000 cycles
        @(posedge clk); #1;
        clr_mon();
        tx_lat = 1000;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (q.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        tx_lat = 3;
        chk("hold_first_send", {31'd0, ok}, 32'd1);
        repeat (500) @(posedge clk);
        #2;
        chk("hold_busy_mid", {31'd0, o_busy}, 32'd1);
        chk("hold_start_mid", {31'd0, o_tx_start}, 32'd0);
        repeat (480) @(posedge clk);
        #2;
        chk("hold_busy_late", {31'd0, o_busy}, 32'd1);
        chk("hold_no_strobes", 32'(q.size()), 32'd1);
        wait_done(ok);
        chk("hold_done_seen", {31'd0, ok}, 32'd1);
        check_stream("hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_mem_dumper.md
DEBUG_MEM_DUMPER -- requirements
Module: debug_mem_dumper

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of the memory debug word.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of memory words dumped per run.
REQ-003 The block SHALL have port i_clock, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: request to start a dump.
REQ-006 The block SHALL have port i_mem_debug, input, DATA_WIDTH bits: the data-memory word currently selected by that memory's debug counter.
REQ-007 The block SHALL have port o_debug, output, 1 bit: one-cycle advance pulse to the data-memory debug counter.
REQ-008 The block SHALL have port o_tx_data, output, 8 bits: byte to the UART transmitter.
REQ-009 The block SHALL have port o_tx_start, output, 1 bit: one-cycle strobe marking o_tx_data valid.
REQ-010 The block SHALL have port i_tx_done, input, 1 bit: one-cycle pulse from the transmitter when the current byte has finished.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port o_done, output, 1 bit: one-cycle pulse at the end of a dump.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, SEND, WAIT, ADVANCE, SETTLE and DONE.
REQ-014 In IDLE, i_start=1 SHALL move the FSM to LOAD and clear word_cnt and byte_cnt.
REQ-015 In every state other than IDLE, i_start SHALL be ignored.
REQ-016 LOAD SHALL capture i_mem_debug into a DATA_WIDTH shift register, then go to SEND.
REQ-017 SEND SHALL drive o_tx_data with byte byte_cnt of the captured word, MSB-first (byte 0 = [31:24]), assert o_tx_start for exactly this one cycle, then go to WAIT.
REQ-018 o_tx_data SHALL hold its value until the next SEND.
REQ-019 In WAIT, the FSM SHALL stay until i_tx_done=1.
REQ-020 When i_tx_done=1 in WAIT and byte_cnt<3, byte_cnt SHALL increment and the FSM SHALL go to SEND.
REQ-021 When i_tx_done=1 in WAIT and byte_cnt=3, the FSM SHALL go to ADVANCE.
REQ-022 i_tx_done SHALL be ignored in every state except WAIT.
REQ-023 ADVANCE SHALL assert o_debug for exactly one cycle and increment word_cnt.
REQ-024 From ADVANCE, the FSM SHALL go to DONE if word_cnt was DEPTH-1, else to SETTLE.
REQ-025 SETTLE SHALL last one cycle, then go to LOAD.
REQ-026 SETTLE SHALL give the memory, which advances its counter on the falling edge, a settle cycle so that LOAD samples the new word.
REQ-027 DONE SHALL assert o_done for one cycle, then go to IDLE.
REQ-028 Each dump SHALL issue exactly DEPTH o_debug pulses, so the memory's 5-bit debug counter wraps back to 0 and consecutive dumps start at word 0.
REQ-029 Each dump SHALL transmit exactly 4*DEPTH bytes (128 at the default DEPTH).
REQ-030 Latency SHALL be: i_start sampled at edge N, LOAD at N+1, first o_tx_start at N+2.
REQ-031 A new i_start SHALL be accepted in the cycle after o_done.
REQ-032 i_start asserted in the same cycle as o_done SHALL be ignored.

Reset
REQ-033 i_reset=0 SHALL immediately force: FSM to IDLE; word_cnt=0; byte_cnt=0; shift register=0; o_tx_data=0x00; o_tx_start=0; o_debug=0; o_busy=0; o_done=0.
REQ-034 A reset mid-dump SHALL abort the dump with no further strobes.
REQ-035 After a mid-dump reset, the memory counter SHALL be resynchronised by the system reset of the memory.
REQ-036 Deassertion of i_reset SHALL take effect at the next rising edge.

Verification
REQ-037 Setup for REQ-038 and REQ-039: memory model with word2=99 and word31=100 (others 0) and a transmitter model answering i_tx_done 3 cycles after each o_tx_start; pulse i_start.
REQ-038 Byte 0 -> 0x00 and the first o_tx_start 2 cycles after i_start.
REQ-039 Bytes 8-11 -> 00 00 00 63; bytes 124-127 -> 00 00 00 64; total 128 strobes; 32 o_debug pulses; one o_done; o_busy low afterward.
REQ-040 Two back-to-back dumps -> identical 128-byte streams, with the memory counter equal to 0 at the start of each.
REQ-041 i_start pulses and spurious i_tx_done pulses outside WAIT during a dump -> stream unchanged; no extra strobes.
REQ-042 i_reset=0 asserted in WAIT of word 5 -> all outputs 0 within the same cycle; no o_done; a subsequent i_start produces the full 128-byte stream.
REQ-043 Transmitter that holds i_tx_done low for 1000 cycles -> FSM remains in WAIT with o_busy=1 and o_tx_start=0, and resumes correctly when i_tx_done arrives.
